// File: rtl/fft_o_switch.sv
// Write-back switch between the FFT butterfly outputs and the two data RAM banks.
// Define FFT_O_SCALE_EN to halve every written re/im half (round half-up, saturating).
module fft_o_switch #(
    parameter int ADDR_WIDTH = 18,
    parameter int DATA_WIDTH = 18
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  first_lev_s,
    input  logic                  butterfly_vld,
    input  logic [DATA_WIDTH-1:0] butterfly_aout,
    input  logic [DATA_WIDTH-1:0] butterfly_bout,
    input  logic [ADDR_WIDTH-1:0] addr_index,
    output logic                  wa_en,
    output logic [ADDR_WIDTH-1:0] wa_addr,
    output logic [DATA_WIDTH-1:0] wa_data,
    output logic                  wb_en,
    output logic [ADDR_WIDTH-1:0] wb_addr,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic                  odd_flush,
    output logic                  level_done,
    output logic                  busy
);

    localparam int HW = DATA_WIDTH / 2;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        DRAIN
    } state_t;

    state_t state, state_next;

    logic [DATA_WIDTH-1:0] a0, b0, b1, qa, qb;
    logic [ADDR_WIDTH-1:0] idx0, idx1, qidx;
    logic                  q_vld, q_vld_next;

    logic                  wr_en_next;
    logic                  flush_next;
    logic [ADDR_WIDTH-1:0] wr_addr_next;
    logic [DATA_WIDTH-1:0] wr_a_next, wr_b_next;
    logic [DATA_WIDTH-1:0] wa_word, wb_word;
    logic                  cap0, cap1, q_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A direct-mode butterfly that collides with a pending paired write is parked
    // in the q* slot; it can only be occupied while the FSM sits in IDLE.
    always_comb begin
        state_next   = state;
        q_vld_next   = q_vld;
        wr_en_next   = 1'b0;
        flush_next   = 1'b0;
        wr_addr_next = idx0;
        wr_a_next    = a0;
        wr_b_next    = b0;
        cap0         = 1'b0;
        cap1         = 1'b0;
        q_load       = 1'b0;
        unique case (state)
            IDLE: begin
                if (q_vld) begin
                    wr_en_next   = 1'b1;
                    wr_addr_next = qidx;
                    wr_a_next    = qa;
                    wr_b_next    = qb;
                    q_vld_next   = 1'b0;
                end
                if (butterfly_vld) begin
                    if (!first_lev_s) begin
                        cap0       = 1'b1;
                        state_next = HOLD;
                    end else if (q_vld) begin
                        q_load     = 1'b1;
                        q_vld_next = 1'b1;
                    end else begin
                        wr_en_next   = 1'b1;
                        wr_addr_next = addr_index;
                        wr_a_next    = butterfly_aout;
                        wr_b_next    = butterfly_bout;
                    end
                end
            end
            HOLD: begin
                wr_en_next = 1'b1;
                if (butterfly_vld && !first_lev_s) begin
                    wr_b_next  = butterfly_aout;
                    cap1       = 1'b1;
                    state_next = DRAIN;
                end else begin
                    flush_next = 1'b1;
                    state_next = IDLE;
                    if (butterfly_vld) begin
                        q_load     = 1'b1;
                        q_vld_next = 1'b1;
                    end
                end
            end
            DRAIN: begin
                wr_en_next   = 1'b1;
                wr_addr_next = idx1;
                wr_a_next    = b0;
                wr_b_next    = b1;
                if (butterfly_vld && !first_lev_s) begin
                    cap0       = 1'b1;
                    state_next = HOLD;
                end else begin
                    state_next = IDLE;
                    if (butterfly_vld) begin
                        q_load     = 1'b1;
                        q_vld_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a0    <= '0;
            b0    <= '0;
            idx0  <= '0;
            b1    <= '0;
            idx1  <= '0;
            qa    <= '0;
            qb    <= '0;
            qidx  <= '0;
            q_vld <= 1'b0;
        end else begin
            q_vld <= q_vld_next;
            if (cap0) begin
                a0   <= butterfly_aout;
                b0   <= butterfly_bout;
                idx0 <= addr_index;
            end
            if (cap1) begin
                b1   <= butterfly_bout;
                idx1 <= addr_index;
            end
            if (q_load) begin
                qa   <= butterfly_aout;
                qb   <= butterfly_bout;
                qidx <= addr_index;
            end
        end
    end

`ifdef FFT_O_SCALE_EN
    function automatic logic [HW-1:0] scale_half(input logic [HW-1:0] h);
        logic signed [HW:0] sum;
        sum = $signed({h[HW-1], h}) + $signed((HW+1)'(1));
        sum = sum >>> 1;
        if (sum[HW] != sum[HW-1]) begin
            return sum[HW] ? {1'b1, {(HW-1){1'b0}}} : {1'b0, {(HW-1){1'b1}}};
        end
        return sum[HW-1:0];
    endfunction

    assign wa_word = {scale_half(wr_a_next[DATA_WIDTH-1:HW]), scale_half(wr_a_next[HW-1:0])};
    assign wb_word = {scale_half(wr_b_next[DATA_WIDTH-1:HW]), scale_half(wr_b_next[HW-1:0])};
`else
    assign wa_word = wr_a_next;
    assign wb_word = wr_b_next;
`endif

    // Output register stage; both banks always share one address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wa_en      <= 1'b0;
            wb_en      <= 1'b0;
            wa_addr    <= '0;
            wb_addr    <= '0;
            wa_data    <= '0;
            wb_data    <= '0;
            odd_flush  <= 1'b0;
            level_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            wa_en      <= wr_en_next;
            wb_en      <= wr_en_next;
            wa_addr    <= wr_en_next ? wr_addr_next : '0;
            wb_addr    <= wr_en_next ? wr_addr_next : '0;
            wa_data    <= wr_en_next ? wa_word : '0;
            wb_data    <= wr_en_next ? wb_word : '0;
            odd_flush  <= flush_next;
            level_done <= wa_en && (state == IDLE) && !q_vld && !butterfly_vld;
            busy       <= (state_next != IDLE) || wr_en_next || q_vld_next;
        end
    end

endmodule
